// File: rtl/pixel_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pixel_seq_ctrl_if
// Description : Control bus between the system controller (master) and the
//               pixel frame sequencer (slave). Carries the frame request and
//               abort inputs, the pixel/ADC strobes, the ramp code and the
//               frame status. With PIXSEQ_EXPCFG_EN defined, it also carries
//               the runtime exposure length.
// Revision    : 1.0 - initial release
// ============================================================================
interface pixel_seq_ctrl_if;
`ifdef PIXSEQ_EXPCFG_EN
    logic [15:0] expose_cycles;
`endif
    logic        start;
    logic        abort;
    logic        erase;
    logic        expose;
    logic        convert;
    logic        read0;
    logic        read1;
    logic        read2;
    logic        read3;
    logic [7:0]  ramp_code;
    logic        busy;
    logic        frame_done;

    // System controller side
    modport master (
`ifdef PIXSEQ_EXPCFG_EN
        output expose_cycles,
`endif
        output start,
        output abort,
        input  erase,
        input  expose,
        input  convert,
        input  read0,
        input  read1,
        input  read2,
        input  read3,
        input  ramp_code,
        input  busy,
        input  frame_done
    );

    // Sequencer side
    modport slave (
`ifdef PIXSEQ_EXPCFG_EN
        input  expose_cycles,
`endif
        input  start,
        input  abort,
        output erase,
        output expose,
        output convert,
        output read0,
        output read1,
        output read2,
        output read3,
        output ramp_code,
        output busy,
        output frame_done
    );
endinterface
`default_nettype wire

// File: rtl/pixel_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pixel_seq_ctrl
// Description : Frame sequencer for the pixel array. A start request runs
//               one frame: erase -> expose -> convert -> read rows 0..3, each
//               phase timed by a 16-bit down-counter. The block also supplies
//               the 8-bit ramp/ADC code during convert. All outputs are
//               registered and decoded from the next state.
//               Optional macro PIXSEQ_EXPCFG_EN: the exposure length comes
//               from bus.expose_cycles, latched on the accepted start.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_seq_ctrl #(
    parameter int unsigned ERASE_CYCLES   = 5,
    parameter int unsigned EXPOSE_CYCLES  = 255,
    parameter int unsigned CONVERT_CYCLES = 255,
    parameter int unsigned READ_CYCLES    = 5
) (
    input  wire logic         clk,
    input  wire logic         reset,   // synchronous, active-low
    pixel_seq_ctrl_if.slave   bus
);

    // A zero length would never let the counter expire cleanly, so it
    // becomes a one-cycle phase.
    localparam logic [15:0] c_ERASE_LEN   = (ERASE_CYCLES   == 0) ? 16'd1 : 16'(ERASE_CYCLES);
    localparam logic [15:0] c_EXPOSE_LEN  = (EXPOSE_CYCLES  == 0) ? 16'd1 : 16'(EXPOSE_CYCLES);
    localparam logic [15:0] c_CONVERT_LEN = (CONVERT_CYCLES == 0) ? 16'd1 : 16'(CONVERT_CYCLES);
    localparam logic [15:0] c_READ_LEN    = (READ_CYCLES    == 0) ? 16'd1 : 16'(READ_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ERASE   = 3'd1,
        S_EXPOSE  = 3'd2,
        S_CONVERT = 3'd3,
        S_READ0   = 3'd4,
        S_READ1   = 3'd5,
        S_READ2   = 3'd6,
        S_READ3   = 3'd7
    } state_t;

    state_t      r_state;
    state_t      w_next;
    state_t      w_succ;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_next;
    logic [15:0] w_load;
    logic [15:0] w_exp_len;
    logic        w_done;
    logic        w_accept;
    logic [7:0]  r_ramp;
    logic [7:0]  w_ramp_next;

    logic        r_erase;
    logic        r_expose;
    logic        r_convert;
    logic        r_read0;
    logic        r_read1;
    logic        r_read2;
    logic        r_read3;
    logic        r_busy;
    logic        r_frame_done;

    // Abort beats start in IDLE, so a frame only begins when abort is low.
    assign w_accept = (r_state == S_IDLE) && bus.start && !bus.abort;

`ifdef PIXSEQ_EXPCFG_EN
    logic [15:0] r_exp_len;

    // Capture the exposure length once per frame so mid-frame changes are ignored.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_exp_len <= c_EXPOSE_LEN;
        end else if (w_accept) begin
            r_exp_len <= (bus.expose_cycles == 16'd0) ? 16'd1 : bus.expose_cycles;
        end
    end

    assign w_exp_len = r_exp_len;
`else
    assign w_exp_len = c_EXPOSE_LEN;
`endif

    // Next-state, phase counter and ramp decode.
    always_comb begin
        w_succ      = S_IDLE;
        w_load      = 16'd0;
        w_next      = r_state;
        w_cnt_next  = r_cnt;
        w_done      = 1'b0;
        w_ramp_next = r_ramp;

        case (r_state)
            S_IDLE:    w_succ = S_ERASE;
            S_ERASE:   w_succ = S_EXPOSE;
            S_EXPOSE:  w_succ = S_CONVERT;
            S_CONVERT: w_succ = S_READ0;
            S_READ0:   w_succ = S_READ1;
            S_READ1:   w_succ = S_READ2;
            S_READ2:   w_succ = S_READ3;
            S_READ3:   w_succ = S_IDLE;
            default:   w_succ = S_IDLE;
        endcase

        // The counter is loaded with length-1 and the phase ends when it reads 0.
        case (w_succ)
            S_ERASE:   w_load = c_ERASE_LEN - 16'd1;
            S_EXPOSE:  w_load = w_exp_len - 16'd1;
            S_CONVERT: w_load = c_CONVERT_LEN - 16'd1;
            S_READ0,
            S_READ1,
            S_READ2,
            S_READ3:   w_load = c_READ_LEN - 16'd1;
            default:   w_load = 16'd0;
        endcase

        if (r_state == S_IDLE) begin
            if (w_accept) begin
                w_next     = w_succ;
                w_cnt_next = w_load;
            end
        end else if (bus.abort) begin
            w_next     = S_IDLE;
            w_cnt_next = 16'd0;
        end else if (r_cnt != 16'd0) begin
            w_cnt_next = r_cnt - 16'd1;
        end else begin
            w_next     = w_succ;
            w_cnt_next = w_load;
            w_done     = (r_state == S_READ3);
        end

        // Ramp starts at 0 in the first convert cycle, then holds until the next erase.
        if (w_next == S_CONVERT) begin
            w_ramp_next = (r_state == S_CONVERT) ? r_ramp + 8'd1 : 8'd0;
        end else if ((w_next == S_ERASE) && (r_state != S_ERASE)) begin
            w_ramp_next = 8'd0;
        end
    end

    // State, phase counter and ramp registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
            r_ramp  <= 8'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_ramp  <= w_ramp_next;
        end
    end

    // Strobes and status registered from the next state for glitch-free outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_erase      <= 1'b0;
            r_expose     <= 1'b0;
            r_convert    <= 1'b0;
            r_read0      <= 1'b0;
            r_read1      <= 1'b0;
            r_read2      <= 1'b0;
            r_read3      <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_erase      <= (w_next == S_ERASE);
            r_expose     <= (w_next == S_EXPOSE);
            r_convert    <= (w_next == S_CONVERT);
            r_read0      <= (w_next == S_READ0);
            r_read1      <= (w_next == S_READ1);
            r_read2      <= (w_next == S_READ2);
            r_read3      <= (w_next == S_READ3);
            r_busy       <= (w_next != S_IDLE);
            r_frame_done <= w_done;
        end
    end

    assign bus.erase      = r_erase;
    assign bus.expose     = r_expose;
    assign bus.convert    = r_convert;
    assign bus.read0      = r_read0;
    assign bus.read1      = r_read1;
    assign bus.read2      = r_read2;
    assign bus.read3      = r_read3;
    assign bus.ramp_code  = r_ramp;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire
